// File: rtl/frame_writer.sv
// Pixel stream to byte-addressed frame buffer writer, bitmap row order.
// Row padding to 4 bytes is built only when FRAME_WRITER_PAD_EN is defined.
//
// state | meaning
// IDLE  | waiting for en && vsync to open a frame
// SKIP  | discarding pipeline-latency pixels after frame start
// WRITE | writing one pixel per en cycle
// DONE  | frame complete, pulse frame_done for one cycle
module frame_writer #(
  parameter int PIXEL_SIZE = 24,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int LATENCY    = 0,
  parameter int ADDR_W     = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [PIXEL_SIZE-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sync_err
);

`ifdef FRAME_WRITER_PAD_EN
  localparam int PAD = (4 - ((3 * WIDTH) % 4)) % 4;
`else
  localparam int PAD = 0;
`endif

  localparam int COL_W  = $clog2(WIDTH + 1);
  localparam int ROW_W  = $clog2(HEIGHT + 2);
  localparam int SKIP_W = $clog2(LATENCY + 2);

  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(3 * WIDTH + PAD);
  localparam logic [ADDR_W-1:0] PIX_BYTES = ADDR_W'(3);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {IDLE, SKIP, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [SKIP_W-1:0]     skip_q, skip_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [PIXEL_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  start;
  logic                  do_write;
  logic [COL_W-1:0]      pix_col;
  logic [ROW_W-1:0]      pix_row;
  logic [ADDR_W-1:0]     pix_addr;
  logic [ADDR_W-1:0]     pix_base;

  // vsync with a pixel restarts the frame from any state
  assign start = en && vsync;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    base_d      = base_q;
    skip_d      = skip_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    do_write    = 1'b0;
    pix_col     = col_q;
    pix_row     = row_q;
    pix_addr    = addr_q;
    pix_base    = base_q;

    if (start) begin
      err_d  = 1'b0;
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
      base_d = '0;
      skip_d = SKIP_INIT;
      if (LATENCY == 0) begin
        do_write = 1'b1;
        pix_col  = '0;
        pix_row  = '0;
        pix_addr = '0;
        pix_base = '0;
        state_d  = WRITE;
      end else if (LATENCY == 1) begin
        state_d = WRITE;
      end else begin
        state_d = SKIP;
      end
    end else begin
      case (state_q)
        SKIP: begin
          if (en) begin
            if (skip_q <= SKIP_W'(1)) begin
              skip_d  = '0;
              state_d = WRITE;
            end else begin
              skip_d = skip_q - SKIP_W'(1);
            end
          end
        end
        WRITE: begin
          if (en) begin
            do_write = 1'b1;
            // early hsync: jump to the next row base and write the pixel there
            if (hsync && (col_q != '0)) begin
              err_d    = 1'b1;
              pix_col  = '0;
              pix_row  = row_q + ROW_W'(1);
              pix_base = base_q + STRIDE;
              pix_addr = base_q + STRIDE;
            end else if (!hsync && (col_q == '0)) begin
              err_d = 1'b1;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    if (do_write) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = pix_addr;
      mem_wdata_d = data;
      if (pix_col == COL_LAST) begin
        if (pix_row == ROW_LAST) begin
          state_d = DONE;
        end
        col_d  = '0;
        row_d  = pix_row + ROW_W'(1);
        addr_d = pix_base + STRIDE;
        base_d = pix_base + STRIDE;
      end else begin
        col_d  = pix_col + COL_W'(1);
        row_d  = pix_row;
        addr_d = pix_addr + PIX_BYTES;
        base_d = pix_base;
      end
    end

    // stays high through the frame_done cycle
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      skip_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      skip_q      <= skip_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: three instances with different geometry,
// random pixel streams compared against a row/column address model.
module tb_frame_writer;

`ifdef FRAME_WRITER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic a_en = 0, a_hs = 0, a_vs = 0; logic [23:0] a_d = '0;
  logic b_en = 0, b_hs = 0, b_vs = 0; logic [23:0] b_d = '0;
  logic c_en = 0, c_hs = 0, c_vs = 0; logic [23:0] c_d = '0;
  logic [19:0] a_addr, b_addr, c_addr;
  logic [23:0] a_wdata, b_wdata, c_wdata;
  logic a_we, a_busy, a_fd, a_err;
  logic b_we, b_busy, b_fd, b_err;
  logic c_we, c_busy, c_fd, c_err;

  frame_writer #(.PIXEL_SIZE(24), .WIDTH(5), .HEIGHT(2), .LATENCY(0), .ADDR_W(20)) u_a (
    .clk(clk), .reset_n(reset_n), .en(a_en), .hsync(a_hs), .vsync(a_vs), .data(a_d),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we), .busy(a_busy),
    .frame_done(a_fd), .sync_err(a_err));

  frame_writer #(.PIXEL_SIZE(24), .WIDTH(4), .HEIGHT(1), .LATENCY(3), .ADDR_W(20)) u_b (
    .clk(clk), .reset_n(reset_n), .en(b_en), .hsync(b_hs), .vsync(b_vs), .data(b_d),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we), .busy(b_busy),
    .frame_done(b_fd), .sync_err(b_err));

  frame_writer #(.PIXEL_SIZE(24), .WIDTH(4), .HEIGHT(2), .LATENCY(0), .ADDR_W(20)) u_c (
    .clk(clk), .reset_n(reset_n), .en(c_en), .hsync(c_hs), .vsync(c_vs), .data(c_d),
    .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_we(c_we), .busy(c_busy),
    .frame_done(c_fd), .sync_err(c_err));

  // captured writes per instance
  logic [19:0] qa_addr[$], qb_addr[$], qc_addr[$];
  logic [23:0] qa_data[$], qb_data[$], qc_data[$];
  int          qa_cyc[$],  qb_cyc[$],  qc_cyc[$];

  always @(negedge clk) begin
    if (a_we) begin qa_addr.push_back(a_addr); qa_data.push_back(a_wdata); qa_cyc.push_back(cyc); end
    if (b_we) begin qb_addr.push_back(b_addr); qb_data.push_back(b_wdata); qb_cyc.push_back(cyc); end
    if (c_we) begin qc_addr.push_back(c_addr); qc_data.push_back(c_wdata); qc_cyc.push_back(cyc); end
  end

  logic [19:0] oa[$];
  logic [23:0] od[$];
  int          oc[$];
  logic [19:0] exp_addr[$];
  logic [23:0] exp_data[$];

  function automatic int stride_of(int w);
    int pad;
    pad = PAD_EN ? (4 - ((3 * w) % 4)) % 4 : 0;
    return 3 * w + pad;
  endfunction

  // pixel k of the stream lands at row*stride + col*3 once latency is dropped
  function automatic void model_frame(logic [23:0] pix[$], int w, int h, int lat);
    int p;
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < pix.size(); k++) begin
      p = k - lat;
      if (p >= 0 && p < w * h) begin
        exp_addr.push_back(20'((p / w) * stride_of(w) + (p % w) * 3));
        exp_data.push_back(pix[k]);
      end
    end
  endfunction

  function automatic logic [47:0] outs(int sel);
    case (sel)
      0:       return {a_addr, a_wdata, a_we, a_busy, a_fd, a_err};
      1:       return {b_addr, b_wdata, b_we, b_busy, b_fd, b_err};
      default: return {c_addr, c_wdata, c_we, c_busy, c_fd, c_err};
    endcase
  endfunction

  task automatic clear_q();
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    qb_addr.delete(); qb_data.delete(); qb_cyc.delete();
    qc_addr.delete(); qc_data.delete(); qc_cyc.delete();
  endtask

  task automatic get_obs(int sel);
    case (sel)
      0:       begin oa = qa_addr; od = qa_data; oc = qa_cyc; end
      1:       begin oa = qb_addr; od = qb_data; oc = qb_cyc; end
      default: begin oa = qc_addr; od = qc_data; oc = qc_cyc; end
    endcase
  endtask

  task automatic drive(int sel, bit en, bit hs, bit vs, logic [23:0] d);
    @(negedge clk);
    case (sel)
      0:       begin a_en = en; a_hs = hs; a_vs = vs; a_d = d; end
      1:       begin b_en = en; b_hs = hs; b_vs = vs; b_d = d; end
      default: begin c_en = en; c_hs = hs; c_vs = vs; c_d = d; end
    endcase
  endtask

  task automatic wait_done(int sel, output bit ok, output int fcyc);
    logic [47:0] o;
    ok = 1'b0;
    fcyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      o = outs(sel);
      if (o[1]) begin ok = 1'b1; fcyc = cyc; break; end
    end
  endtask

  task automatic run_frame(int sel, int w, int h, int lat, bit gaps, string tag);
    logic [23:0] pix[$];
    logic [47:0] o;
    int npix, ng, fcyc;
    bit ok;
    npix = lat + w * h;
    for (int k = 0; k < npix; k++) pix.push_back(24'($urandom));
    clear_q();
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++)
          drive(sel, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
      end
      drive(sel, 1'b1, (k == 0) || (k >= lat && ((k - lat) % w) == 0), k == 0, pix[k]);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(sel, ok, fcyc);
    n_checks++;
    if (!ok) $display("FAIL %s frame_done: not seen within 50 cycles", tag);
    else n_pass++;
    o = outs(sel);
    n_checks++;
    if (o[2] !== 1'b1) $display("FAIL %s busy_at_done: got %0b expected 1", tag, o[2]);
    else n_pass++;
    n_checks++;
    if (o[0] !== 1'b0) $display("FAIL %s sync_err: got %0b expected 0", tag, o[0]);
    else n_pass++;
    model_frame(pix, w, h, lat);
    get_obs(sel);
    n_checks++;
    if (oa.size() != exp_addr.size())
      $display("FAIL %s write_count: got %0d expected %0d", tag, oa.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < oa.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (oa[i] !== exp_addr[i] || od[i] !== exp_data[i])
        $display("FAIL %s write[%0d]: got addr %0d data %06h expected addr %0d data %06h",
                 tag, i, oa[i], od[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    if (ok && oc.size() > 0) begin
      n_checks++;
      if (fcyc != oc[oc.size() - 1] + 1)
        $display("FAIL %s done_timing: got cycle %0d expected %0d", tag, fcyc, oc[oc.size() - 1] + 1);
      else n_pass++;
    end
    @(negedge clk);
    o = outs(sel);
    n_checks++;
    if (o[2:1] !== 2'b00) $display("FAIL %s idle_after: got busy,done %02b expected 00", tag, o[2:1]);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [47:0] o;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      o = outs(s);
      n_checks++;
      if (o !== 48'h0) $display("FAIL reset_outputs[%0d]: got %012h expected 0", s, o);
      else n_pass++;
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_padded_frame();
    int exp_pad[10]   = '{0, 3, 6, 9, 12, 16, 19, 22, 25, 28};
    int exp_nopad[10] = '{0, 3, 6, 9, 12, 15, 18, 21, 24, 27};
    int ea, fcyc;
    bit ok;
    logic [47:0] o;
    clear_q();
    for (int k = 0; k < 10; k++)
      drive(0, 1'b1, (k % 5) == 0, k == 0, 24'(k + 1));
    drive(0, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(0, ok, fcyc);
    get_obs(0);
    n_checks++;
    if (oa.size() != 10) $display("FAIL layout_count: got %0d expected 10", oa.size());
    else n_pass++;
    for (int i = 0; i < oa.size() && i < 10; i++) begin
      ea = PAD_EN ? exp_pad[i] : exp_nopad[i];
      n_checks++;
      if (oa[i] !== 20'(ea) || od[i] !== 24'(i + 1))
        $display("FAIL layout[%0d]: got addr %0d data %06h expected addr %0d data %06h",
                 i, oa[i], od[i], ea, i + 1);
      else n_pass++;
    end
    n_checks++;
    if (!ok || oc.size() == 0 || fcyc != oc[oc.size() - 1] + 1)
      $display("FAIL layout_done: got done ok %0b cycle %0d", ok, fcyc);
    else n_pass++;
    @(negedge clk);
    o = outs(0);
    n_checks++;
    if (o[2] !== 1'b0) $display("FAIL layout_busy_after: got %0b expected 0", o[2]);
    else n_pass++;
  endtask

  task automatic test_latency();
    int fcyc;
    bit ok;
    logic [47:0] o;
    clear_q();
    for (int k = 0; k < 7; k++)
      drive(1, 1'b1, k == 0 || k == 3, k == 0, 24'(10 + k));
    drive(1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(1, ok, fcyc);
    o = outs(1);
    n_checks++;
    if (!ok || o[0] !== 1'b0) $display("FAIL latency_done_err: got done %0b err %0b expected 1 0", ok, o[0]);
    else n_pass++;
    get_obs(1);
    n_checks++;
    if (oa.size() != 4) $display("FAIL latency_count: got %0d expected 4", oa.size());
    else n_pass++;
    for (int i = 0; i < oa.size() && i < 4; i++) begin
      n_checks++;
      if (oa[i] !== 20'(3 * i) || od[i] !== 24'(13 + i))
        $display("FAIL latency_write[%0d]: got addr %0d data %06h expected addr %0d data %06h",
                 i, oa[i], od[i], 3 * i, 13 + i);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_sync_err();
    int exp_a[6] = '{0, 3, 12, 15, 18, 21};
    logic [23:0] d[8];
    logic [47:0] o;
    int fcyc;
    bit ok;
    for (int i = 0; i < 8; i++) d[i] = 24'($urandom);
    clear_q();
    drive(2, 1'b1, 1'b1, 1'b1, d[0]);
    drive(2, 1'b1, 1'b0, 1'b0, d[1]);
    drive(2, 1'b1, 1'b1, 1'b0, d[2]);
    o = outs(2);
    n_checks++;
    if (o[0] !== 1'b0) $display("FAIL err_before_hsync: got %0b expected 0", o[0]);
    else n_pass++;
    drive(2, 1'b1, 1'b0, 1'b0, d[3]);
    o = outs(2);
    n_checks++;
    if (o[0] !== 1'b1) $display("FAIL err_after_hsync: got %0b expected 1", o[0]);
    else n_pass++;
    drive(2, 1'b1, 1'b0, 1'b0, d[4]);
    drive(2, 1'b1, 1'b0, 1'b0, d[5]);
    drive(2, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(2, ok, fcyc);
    o = outs(2);
    n_checks++;
    if (!ok || o[0] !== 1'b1) $display("FAIL err_frame_done: got done %0b err %0b expected 1 1", ok, o[0]);
    else n_pass++;
    get_obs(2);
    n_checks++;
    if (oa.size() != 6) $display("FAIL err_count: got %0d expected 6", oa.size());
    else n_pass++;
    for (int i = 0; i < oa.size() && i < 6; i++) begin
      n_checks++;
      if (oa[i] !== 20'(exp_a[i]) || od[i] !== d[i])
        $display("FAIL err_write[%0d]: got addr %0d data %06h expected addr %0d data %06h",
                 i, oa[i], od[i], exp_a[i], d[i]);
      else n_pass++;
    end
    // a fresh vsync frame clears the sticky flag
    for (int k = 0; k < 8; k++) begin
      drive(2, 1'b1, (k % 4) == 0, k == 0, d[k]);
      if (k == 1) begin
        o = outs(2);
        n_checks++;
        if (o[0] !== 1'b0) $display("FAIL err_cleared: got %0b expected 0", o[0]);
        else n_pass++;
      end
    end
    drive(2, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(2, ok, fcyc);
    o = outs(2);
    n_checks++;
    if (!ok || o[0] !== 1'b0) $display("FAIL err_clean_frame: got done %0b err %0b expected 1 0", ok, o[0]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_vsync_restart();
    logic [23:0] pix[$];
    logic [47:0] o;
    int fcyc;
    bit ok;
    clear_q();
    for (int k = 0; k < 3; k++) drive(0, 1'b1, k == 0, k == 0, 24'($urandom));
    for (int k = 0; k < 10; k++) pix.push_back(24'($urandom));
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'b1, (k % 5) == 0, k == 0, pix[k]);
      if (k == 1) begin
        o = outs(0);
        n_checks++;
        if (o[0] !== 1'b0) $display("FAIL restart_err: got %0b expected 0", o[0]);
        else n_pass++;
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_done(0, ok, fcyc);
    model_frame(pix, 5, 2, 0);
    get_obs(0);
    n_checks++;
    if (!ok || oa.size() != 13) $display("FAIL restart_count: got done %0b writes %0d expected 1 13", ok, oa.size());
    else n_pass++;
    for (int i = 3; i < oa.size() && i < 13; i++) begin
      n_checks++;
      if (oa[i] !== exp_addr[i - 3] || od[i] !== exp_data[i - 3])
        $display("FAIL restart_write[%0d]: got addr %0d data %06h expected addr %0d data %06h",
                 i, oa[i], od[i], exp_addr[i - 3], exp_data[i - 3]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_en_gaps();
    logic [47:0] o;
    clear_q();
    drive(0, 1'b1, 1'b1, 1'b1, 24'h111111);
    drive(0, 1'b0, 1'b1, 1'b0, 24'hdeadbe);
    drive(0, 1'b0, 1'b0, 1'b1, 24'hbadbad);
    o = outs(0);
    n_checks++;
    if (o[3] !== 1'b0) $display("FAIL gap_we: got %0b expected 0", o[3]);
    else n_pass++;
    drive(0, 1'b1, 1'b0, 1'b0, 24'h222222);
    drive(0, 1'b0, 1'b0, 1'b0, 24'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 24'h0);
    get_obs(0);
    n_checks++;
    if (oa.size() != 2 || oa[0] !== 20'd0 || oa[1] !== 20'd3 || od[1] !== 24'h222222)
      $display("FAIL gap_writes: got %0d writes first addrs %0d,%0d expected 2 writes at 0,3",
               oa.size(), oa.size() > 0 ? oa[0] : 20'd0, oa.size() > 1 ? oa[1] : 20'd0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] o;
    drive(0, 1'b1, 1'b0, 1'b0, 24'h333333);
    drive(0, 1'b0, 1'b0, 1'b0, 24'h0);
    #2 reset_n = 1'b0;
    #1;
    o = outs(0);
    n_checks++;
    if (o !== 48'h0) $display("FAIL mid_reset_outputs: got %012h expected 0", o);
    else n_pass++;
    get_obs(0);
    n_checks++;
    if (oa.size() != 3 || oa[2] !== 20'd6)
      $display("FAIL pre_reset_writes: got %0d writes expected 3 ending at 6", oa.size());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, 5, 2, 0, 1'b0, "post_reset");
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 4; r++) begin
      run_frame(0, 5, 2, 0, 1'b1, "rand_a");
      run_frame(1, 4, 1, 3, 1'b1, "rand_b");
      run_frame(2, 4, 2, 0, 1'b1, "rand_c");
    end
  endtask

  initial begin
    test_reset();
    test_padded_frame();
    test_latency();
    test_sync_err();
    test_vsync_restart();
    test_en_gaps();
    test_reset_mid_frame();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
